incr_result_checker: RTL and testbench
======================================

// Module: incr_result_checker
// PURPOSE
//  Downstream scoreboard stage for the incrementing top-level datapath. For each sample it
//  takes the stimulus sent to the top (in_small/in_quad/in_wide, reset_l) and the response
//  it produced (out_*), computes the expected value and compares. It counts samples and
//  errors, and queues one record per failing sample in an error FIFO drained by a handshake.
// PARAMETERS
//  CNT_W          16  width of sample/error counters and err_index; counters saturate
//  ERR_DEPTH      4   error-record FIFO depth (power of 2, >=2)
//  STOP_ON_ERROR  0   1: enter HALT on first mismatch; 0: keep running
// PORTS
//  clk          in   1      single clock
//  reset        in   1      synchronous, active-high
//  enable       in   1      level; IDLE->RUN when high
//  clear        in   1      sync pulse; flush pipeline/FIFO, zero counters, go IDLE
//  chk_valid    in   1      sample present
//  chk_ready    out  1      sample accepted when chk_valid & chk_ready
//  dut_reset_l  in   1      reset_l driven to the top for this sample
//  stim_small   in   2      in_small driven to the top
//  stim_quad    in   40     in_quad driven to the top
//  stim_wide    in   70     in_wide driven to the top
//  resp_small   in   2      out_small returned by the top
//  resp_quad    in   40     out_quad returned by the top
//  resp_wide    in   70     out_wide returned by the top
//  err_valid    out  1      FIFO head holds an error record
//  err_ready    in   1      pop when err_valid & err_ready
//  err_field    out  3      mismatch mask: [0] small, [1] quad, [2] wide
//  err_index    out  CNT_W  0-based sample number of the failing sample
//  sample_count out  CNT_W  samples compared
//  error_count  out  CNT_W  samples with any mismatch
//  halted       out  1      state==HALT
// BEHAVIOUR
//  - Reset: state IDLE; chk_ready=0, err_valid=0, err_field=0, err_index=0, counts=0,
//    halted=0, pipeline empty.
//  - FSM: IDLE -(enable)-> RUN; RUN -(!enable)-> IDLE; RUN -(mismatch & STOP_ON_ERROR)-> HALT;
//    HALT exits only on clear or reset. clear beats every other transition.
//  - chk_ready = (state==RUN) & (fifo_count + s1_valid < ERR_DEPTH). A failing sample
//    therefore always has a FIFO slot; no record is ever dropped.
//  - Stage 1: on accept at edge N, register stim/resp/dut_reset_l, s1_valid=1.
//  - Stage 2: at edge N+1, compare. expected = dut_reset_l ? stim+1 mod 2^W : 0, per field,
//    W=2/40/70 (carry out discarded: all-ones -> 0). sample_count++. If mask!=0:
//    error_count++ and push {mask, index=pre-increment sample_count}. err_valid is visible
//    from the cycle after edge N+1.
//  - Full rate: one sample per cycle while FIFO has room.
//  - Counters saturate at 2^CNT_W-1. Index then stays at max.
//  - Leaving RUN (to IDLE or HALT) does not drop the stage-1 sample; it still completes.
//  - FIFO push and pop in the same cycle: both occur, count unchanged. Pop while empty: ignored.
//  - clear and chk_valid in the same cycle: clear wins, sample dropped, chk_ready=0 that cycle.
//  - reset mid-operation: same as reset.
// STRUCTURE
//  - Package incr_chk_pkg: SMALL_W=2, QUAD_W=40, WIDE_W=70; typedef enum {IDLE,RUN,HALT}
//    chk_state_t; typedef struct packed {logic [2:0] field; logic [CNT_W-1:0] index;} err_rec_t
//    (index width from a package default, overridden as needed).
//  - One sub-module: err_record_fifo (sync FIFO, parameters DEPTH and WIDTH, count output,
//    sync active-high reset plus flush input driven by clear).
//  - Compare logic, counters and FSM stay in this module.
// TESTING
//  1 Wrap: dut_reset_l=1, stim_small=2'b11, stim_quad=40'hFF_FFFF_FFFF, stim_wide all-ones,
//    all resp=0 -> sample_count=1, error_count=0, err_valid stays 0.
//  2 Quad mismatch: stim_quad=40'h10, resp_quad=40'h12, others correct -> err_field=3'b010,
//    err_index=0, error_count=1.
//  3 Reset-phase: dut_reset_l=0 with all resp=0 -> pass. Then resp_small=2'b01 -> err_field=3'b001.
//  4 Backpressure: ERR_DEPTH=4, err_ready=0, 6 back-to-back failing samples -> chk_ready
//    drops after 4 accepts. Then err_ready=1 -> indices 0,1,2,3 pop in order, remaining 2 accepted.
//  5 STOP_ON_ERROR=1: samples 0,1 pass, sample 2 fails -> halted=1, chk_ready=0. Then clear
//    -> counts=0, state IDLE, then RUN with enable=1.
//  6 Saturation: CNT_W=4, 20 failing samples with err_ready=1 -> sample_count=error_count=15
//    and held there. clear asserted together with chk_valid -> that sample not counted.

Source files
------------

// File: rtl/incr_chk_pkg.sv
// Shared widths, FSM state and error-record layout for the incrementing-datapath checker.
package incr_chk_pkg;

    localparam int SMALL_W   = 2;
    localparam int QUAD_W    = 40;
    localparam int WIDE_W    = 70;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } chk_state_t;

    // Record layout; the checker packs {field, index} the same way at its own CNT_W.
    typedef struct packed {
        logic [2:0]           field;
        logic [CNT_W_DEF-1:0] index;
    } err_rec_t;

endpackage

// File: rtl/err_record_fifo.sv
// Small synchronous FIFO for error records with occupancy count and a flush input.
module err_record_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == {(PTR_W+1){1'b0}});
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != FULL_COUNT) || do_pop);
    assign head    = mem[rd_ptr];

    // Record storage; slots are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= {PTR_W{1'b0}};
            rd_ptr <= {PTR_W{1'b0}};
            count  <= {(PTR_W+1){1'b0}};
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/incr_result_checker.sv
// Scoreboard stage for the incrementing datapath: compares each response with stim+1
// (or zero while the top was held in reset), counts samples/errors, queues failures.
module incr_result_checker
    import incr_chk_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int ERR_DEPTH     = 4,
    parameter bit STOP_ON_ERROR = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic               chk_valid,
    output logic               chk_ready,
    input  logic               dut_reset_l,
    input  logic [SMALL_W-1:0] stim_small,
    input  logic [QUAD_W-1:0]  stim_quad,
    input  logic [WIDE_W-1:0]  stim_wide,
    input  logic [SMALL_W-1:0] resp_small,
    input  logic [QUAD_W-1:0]  resp_quad,
    input  logic [WIDE_W-1:0]  resp_wide,
    output logic               err_valid,
    input  logic               err_ready,
    output logic [2:0]         err_field,
    output logic [CNT_W-1:0]   err_index,
    output logic [CNT_W-1:0]   sample_count,
    output logic [CNT_W-1:0]   error_count,
    output logic               halted
);

    localparam int REC_W  = 3 + CNT_W;
    localparam int FCNT_W = $clog2(ERR_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    chk_state_t         state;
    logic               accept;
    logic               s1_valid;
    logic               s1_reset_l;
    logic [SMALL_W-1:0] s1_stim_small, s1_resp_small, exp_small;
    logic [QUAD_W-1:0]  s1_stim_quad, s1_resp_quad, exp_quad;
    logic [WIDE_W-1:0]  s1_stim_wide, s1_resp_wide, exp_wide;
    logic [2:0]         mask;
    logic               mismatch;
    logic [FCNT_W-1:0]  fifo_count;
    logic               fifo_empty;
    logic [REC_W-1:0]   fifo_head;

    // A sample is only taken when the one already in stage 1 is guaranteed a FIFO slot.
    always_comb begin
        chk_ready = 1'b0;
        if ((state == RUN) && !clear && !reset &&
            ((int'(fifo_count) + int'(s1_valid)) < ERR_DEPTH)) begin
            chk_ready = 1'b1;
        end else begin
            chk_ready = 1'b0;
        end
    end

    assign accept = chk_valid && chk_ready;

    // Stage 1: capture stimulus and response of the accepted sample.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            s1_valid      <= 1'b0;
            s1_reset_l    <= 1'b0;
            s1_stim_small <= {SMALL_W{1'b0}};
            s1_stim_quad  <= {QUAD_W{1'b0}};
            s1_stim_wide  <= {WIDE_W{1'b0}};
            s1_resp_small <= {SMALL_W{1'b0}};
            s1_resp_quad  <= {QUAD_W{1'b0}};
            s1_resp_wide  <= {WIDE_W{1'b0}};
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_reset_l    <= dut_reset_l;
                s1_stim_small <= stim_small;
                s1_stim_quad  <= stim_quad;
                s1_stim_wide  <= stim_wide;
                s1_resp_small <= resp_small;
                s1_resp_quad  <= resp_quad;
                s1_resp_wide  <= resp_wide;
            end
        end
    end

    // Stage 2 compare: carry out of each increment is discarded by the field width.
    always_comb begin
        exp_small = {SMALL_W{1'b0}};
        exp_quad  = {QUAD_W{1'b0}};
        exp_wide  = {WIDE_W{1'b0}};
        if (s1_reset_l) begin
            exp_small = s1_stim_small + SMALL_W'(1);
            exp_quad  = s1_stim_quad + QUAD_W'(1);
            exp_wide  = s1_stim_wide + WIDE_W'(1);
        end else begin
            exp_small = {SMALL_W{1'b0}};
            exp_quad  = {QUAD_W{1'b0}};
            exp_wide  = {WIDE_W{1'b0}};
        end
        mask     = {exp_wide != s1_resp_wide, exp_quad != s1_resp_quad, exp_small != s1_resp_small};
        mismatch = s1_valid && (mask != 3'b000);
    end

    // Saturating sample and error counters.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sample_count <= {CNT_W{1'b0}};
            error_count  <= {CNT_W{1'b0}};
        end else if (s1_valid) begin
            if (sample_count != CNT_MAX) begin
                sample_count <= sample_count + CNT_W'(1);
            end
            if (mismatch && (error_count != CNT_MAX)) begin
                error_count <= error_count + CNT_W'(1);
            end
        end
    end

    // Control FSM; a pending stage-1 sample still completes after leaving RUN.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (mismatch && STOP_ON_ERROR) begin
                        state <= HALT;
                    end else if (!enable) begin
                        state <= IDLE;
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    assign halted = (state == HALT);

    err_record_fifo #(
        .DEPTH (ERR_DEPTH),
        .WIDTH (REC_W)
    ) u_err_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (clear),
        .push      (mismatch),
        .push_data ({mask, sample_count}),
        .pop       (err_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign err_valid = !fifo_empty;
    assign err_field = err_valid ? fifo_head[REC_W-1 -: 3] : 3'b000;
    assign err_index = err_valid ? fifo_head[CNT_W-1:0] : {CNT_W{1'b0}};

endmodule

// File: tb/tb_incr_result_checker.sv
// Self-checking bench: three checker instances (default, stop-on-error, 4-bit counters)
// sharing the sample buses; a per-instance scoreboard predicts every error record.
module tb_incr_result_checker;

    typedef struct packed {
        logic [2:0]  field;
        logic [15:0] index;
    } sb_rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable    [3];
    logic        clear     [3];
    logic        chk_valid [3];
    logic        err_ready [3];
    logic        chk_ready [3];
    logic        err_valid [3];
    logic        halted    [3];
    logic [2:0]  err_field [3];
    logic [15:0] err_index [3];
    logic [15:0] sample_count [3];
    logic [15:0] error_count  [3];
    logic        dut_reset_l;
    logic [1:0]  stim_small, resp_small;
    logic [39:0] stim_quad, resp_quad;
    logic [69:0] stim_wide, resp_wide;

    sb_rec_t     sb_q [3][$];
    logic [15:0] mdl_samples [3];
    logic [15:0] mdl_errors  [3];
    int          check_count = 0;
    int          error_total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CW  = (g == 2) ? 4 : 16;
        localparam bit SOE = (g == 1);
        logic [CW-1:0] idx, sc, ec;
        incr_result_checker #(.CNT_W(CW), .ERR_DEPTH(4), .STOP_ON_ERROR(SOE)) dut (
            .clk(clk), .reset(reset), .enable(enable[g]), .clear(clear[g]),
            .chk_valid(chk_valid[g]), .chk_ready(chk_ready[g]), .dut_reset_l(dut_reset_l),
            .stim_small(stim_small), .stim_quad(stim_quad), .stim_wide(stim_wide),
            .resp_small(resp_small), .resp_quad(resp_quad), .resp_wide(resp_wide),
            .err_valid(err_valid[g]), .err_ready(err_ready[g]), .err_field(err_field[g]),
            .err_index(idx), .sample_count(sc), .error_count(ec), .halted(halted[g]));
        assign err_index[g]    = 16'(idx);
        assign sample_count[g] = 16'(sc);
        assign error_count[g]  = 16'(ec);
    end

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_total++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of the checker's verdict for the sample currently on the buses.
    function automatic logic [2:0] model_mask();
        logic [1:0]  es;
        logic [39:0] eq;
        logic [69:0] ew;
        es = 2'd0;
        eq = 40'd0;
        ew = 70'd0;
        if (dut_reset_l) begin
            es = stim_small + 2'd1;
            eq = stim_quad + 40'd1;
            ew = stim_wide + 70'd1;
        end
        return {ew != resp_wide, eq != resp_quad, es != resp_small};
    endfunction

    // Scoreboard: checks popped records, then predicts records for accepted samples.
    always @(negedge clk) begin
        logic [15:0] maxc;
        logic [2:0]  m;
        sb_rec_t     rec;
        for (int i = 0; i < 3; i++) begin
            if (reset || clear[i]) begin
                mdl_samples[i] = 16'd0;
                mdl_errors[i]  = 16'd0;
                sb_q[i].delete();
            end else begin
                if (err_valid[i] && err_ready[i]) begin
                    if (sb_q[i].size() == 0) begin
                        check_value("err_unexpected", 1, 0);
                    end else begin
                        rec = sb_q[i].pop_front();
                        check_value("err_field", err_field[i], rec.field);
                        check_value("err_index", err_index[i], rec.index);
                    end
                end
                if (chk_valid[i] && chk_ready[i]) begin
                    maxc = (i == 2) ? 16'd15 : 16'hFFFF;
                    m = model_mask();
                    rec.field = m;
                    rec.index = mdl_samples[i];
                    if (mdl_samples[i] != maxc) mdl_samples[i]++;
                    if (m != 3'b000) begin
                        if (mdl_errors[i] != maxc) mdl_errors[i]++;
                        sb_q[i].push_back(rec);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic rl, input logic [1:0] s, input logic [39:0] q,
                        input logic [69:0] w, input logic [1:0] rs, input logic [39:0] rq,
                        input logic [69:0] rw);
        int waited = 0;
        dut_reset_l = rl;
        stim_small = s;  stim_quad = q;  stim_wide = w;
        resp_small = rs; resp_quad = rq; resp_wide = rw;
        chk_valid[i] = 1'b1;
        while (!chk_ready[i] && waited < 50) begin
            step();
            waited++;
        end
        if (!chk_ready[i]) check_value("accept_timeout", 1, 0);
        step();
    endtask

    task automatic drain(input int i);
        int waited = 0;
        chk_valid[i] = 1'b0;
        err_ready[i] = 1'b1;
        step();
        step();
        while ((sb_q[i].size() != 0 || err_valid[i]) && waited < 40) begin
            step();
            waited++;
        end
        check_value("drain_empty", sb_q[i].size(), 0);
        check_value("model_samples", sample_count[i], mdl_samples[i]);
        check_value("model_errors", error_count[i], mdl_errors[i]);
    endtask

    task automatic clear_inst(input int i);
        chk_valid[i] = 1'b0;
        step();
        step();
        clear[i] = 1'b1;
        step();
        clear[i] = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enable[i] = 1'b0; clear[i] = 1'b0; chk_valid[i] = 1'b0; err_ready[i] = 1'b0;
        end
        dut_reset_l = 1'b0;
        stim_small = 2'd0;  stim_quad = 40'd0; stim_wide = 70'd0;
        resp_small = 2'd0;  resp_quad = 40'd0; resp_wide = 70'd0;
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            check_value("rst_chk_ready", chk_ready[i], 0);
            check_value("rst_err_valid", err_valid[i], 0);
            check_value("rst_err_field", err_field[i], 0);
            check_value("rst_err_index", err_index[i], 0);
            check_value("rst_sample_count", sample_count[i], 0);
            check_value("rst_error_count", error_count[i], 0);
            check_value("rst_halted", halted[i], 0);
        end
        reset = 1'b0;
        step();

        // Wrap: all-ones stimulus increments to zero in every field.
        enable[0] = 1'b1;
        step();
        send(0, 1'b1, 2'b11, {40{1'b1}}, {70{1'b1}}, 2'b00, 40'd0, 70'd0);
        chk_valid[0] = 1'b0;
        repeat (3) step();
        check_value("wrap_samples", sample_count[0], 1);
        check_value("wrap_errors", error_count[0], 0);
        check_value("wrap_err_valid", err_valid[0], 0);

        // Quad-only mismatch on a freshly cleared checker.
        clear_inst(0);
        send(0, 1'b1, 2'b01, 40'h10, 70'h5, 2'b10, 40'h12, 70'h6);
        chk_valid[0] = 1'b0;
        step();
        check_value("quad_err_valid", err_valid[0], 1);
        check_value("quad_err_field", err_field[0], 3'b010);
        check_value("quad_err_index", err_index[0], 0);
        check_value("quad_errors", error_count[0], 1);
        drain(0);

        // Reset phase: response must be zero regardless of stimulus.
        clear_inst(0);
        err_ready[0] = 1'b0;
        send(0, 1'b0, 2'b10, 40'h1234, 70'h77, 2'b00, 40'd0, 70'd0);
        send(0, 1'b0, 2'b10, 40'h1234, 70'h77, 2'b01, 40'd0, 70'd0);
        chk_valid[0] = 1'b0;
        repeat (2) step();
        check_value("rphase_err_field", err_field[0], 3'b001);
        check_value("rphase_err_index", err_index[0], 1);
        check_value("rphase_samples", sample_count[0], 2);
        drain(0);

        // Backpressure: four failing samples fill the FIFO, then the stage stalls.
        clear_inst(0);
        err_ready[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_value("bp_ready_open", chk_ready[0], 1);
            send(0, 1'b1, 2'b11, 40'(k), {70{1'b1}}, 2'b00, 40'd0, 70'd0);
        end
        check_value("bp_ready_low", chk_ready[0], 0);
        repeat (3) step();
        check_value("bp_ready_held", chk_ready[0], 0);
        check_value("bp_err_index_head", err_index[0], 0);
        err_ready[0] = 1'b1;
        send(0, 1'b1, 2'b11, 40'd4, {70{1'b1}}, 2'b00, 40'd0, 70'd0);
        send(0, 1'b1, 2'b11, 40'd5, {70{1'b1}}, 2'b00, 40'd0, 70'd0);
        drain(0);
        check_value("bp_samples", sample_count[0], 6);
        check_value("bp_errors", error_count[0], 6);
        enable[0] = 1'b0;

        // Stop on error: third sample fails and freezes the checker until clear.
        enable[1] = 1'b1;
        err_ready[1] = 1'b1;
        step();
        send(1, 1'b1, 2'b00, 40'd7, 70'd9, 2'b01, 40'd8, 70'd10);
        send(1, 1'b1, 2'b01, 40'd1, 70'd2, 2'b10, 40'd2, 70'd3);
        send(1, 1'b1, 2'b01, 40'd1, 70'd2, 2'b10, 40'd2, 70'd4);
        chk_valid[1] = 1'b0;
        repeat (2) step();
        check_value("halt_halted", halted[1], 1);
        check_value("halt_ready", chk_ready[1], 0);
        check_value("halt_samples", sample_count[1], 3);
        check_value("halt_errors", error_count[1], 1);
        chk_valid[1] = 1'b1;
        step();
        check_value("halt_held", chk_ready[1], 0);
        chk_valid[1] = 1'b0;
        clear[1] = 1'b1;
        step();
        clear[1] = 1'b0;
        check_value("clr_halted", halted[1], 0);
        check_value("clr_samples", sample_count[1], 0);
        check_value("clr_errors", error_count[1], 0);
        check_value("clr_idle_ready", chk_ready[1], 0);
        step();
        check_value("clr_run_ready", chk_ready[1], 1);
        check_value("halt_sb_empty", sb_q[1].size(), 0);

        // Saturation with 4-bit counters, then clear racing a valid sample.
        enable[2] = 1'b1;
        err_ready[2] = 1'b1;
        step();
        for (int k = 0; k < 20; k++) begin
            send(2, 1'b1, 2'b00, 40'(k), 70'd0, 2'b00, 40'(k + 1), 70'd0);
        end
        drain(2);
        check_value("sat_samples", sample_count[2], 15);
        check_value("sat_errors", error_count[2], 15);
        repeat (3) step();
        check_value("sat_samples_held", sample_count[2], 15);
        dut_reset_l = 1'b1;
        stim_small = 2'b00;
        resp_small = 2'b00;
        chk_valid[2] = 1'b1;
        clear[2] = 1'b1;
        #1;
        check_value("clr_race_ready", chk_ready[2], 0);
        step();
        clear[2] = 1'b0;
        chk_valid[2] = 1'b0;
        repeat (3) step();
        check_value("clr_race_samples", sample_count[2], 0);
        check_value("clr_race_errors", error_count[2], 0);
        check_value("clr_race_err_valid", err_valid[2], 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_total);
        $finish;
    end

endmodule
